// File: rtl/swerv_el2_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swerv_el2_trace_pkg
// Description : Shared definitions for the EL2 pipeline trace encoder.
//               Holds the event mask bit positions, the trace header field
//               positions, the snapshot record layout, the serializer state
//               encoding and the end-of-test marker instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package swerv_el2_trace_pkg;

  // Event mask bit positions
  localparam int MASK_WB  = 0;
  localparam int MASK_LWB = 1;
  localparam int MASK_EX  = 2;
  localparam int MASK_DE  = 3;
  localparam int MASK_IF  = 4;

  // Header word field positions
  localparam int HDR_TS_LSB   = 16;
  localparam int HDR_OVF_BIT  = 15;
  localparam int HDR_LOAD_BIT = 5;

  // Decode of this instruction arms the end-of-test detector
  localparam logic [31:0] FINISH_MARKER = 32'h00002013;

  // Serializer states; numeric order matches the payload emission order
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_WB    = 3'd2;
  localparam logic [2:0] ST_EX    = 3'd3;
  localparam logic [2:0] ST_DEPC  = 3'd4;
  localparam logic [2:0] ST_DEINS = 3'd5;
  localparam logic [2:0] ST_IF    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_HDR   = ST_HDR,
    S_WB    = ST_WB,
    S_EX    = ST_EX,
    S_DEPC  = ST_DEPC,
    S_DEINS = ST_DEINS,
    S_IF    = ST_IF
  } trace_state_e;

  typedef struct packed {
    logic [15:0] ts;
    logic        ovf;
    logic        is_load;
    logic [4:0]  mask;
    logic [31:0] wb_pc;
    logic [31:0] ex_pc;
    logic [31:0] de_pc;
    logic [31:0] de_insn;
    logic [31:0] if_pc;
  } trace_snap_t;

  // Word that follows 'cur' within a record; ST_IDLE means 'cur' is the last.
  function automatic logic [2:0] trace_next_state(input logic [2:0] cur,
                                                  input logic [4:0] mask);
    logic [2:0] nxt;
    nxt = ST_IDLE;
    if (cur == ST_DEPC)
      nxt = ST_DEINS;
    else if (cur == ST_HDR && mask[MASK_WB])
      nxt = ST_WB;
    else if (cur >= ST_HDR && cur <= ST_WB && mask[MASK_EX])
      nxt = ST_EX;
    else if (cur >= ST_HDR && cur <= ST_EX && mask[MASK_DE])
      nxt = ST_DEPC;
    else if (cur >= ST_HDR && cur <= ST_DEINS && mask[MASK_IF])
      nxt = ST_IF;
    return nxt;
  endfunction

  function automatic logic [31:0] trace_header(input trace_snap_t s);
    logic [31:0] w;
    w                   = '0;
    w[HDR_TS_LSB +: 16] = s.ts;
    w[HDR_OVF_BIT]      = s.ovf;
    w[HDR_LOAD_BIT]     = s.is_load;
    w[4:0]              = s.mask;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/swerv_el2_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : swerv_el2_trace_fifo
// Description : Synchronous single-clock FIFO, one push and one pop per cycle.
//               Head entry is presented combinationally on pop_data.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               push, push_data     - write request (ignored when full)
//               pop, pop_data       - read request (ignored when empty), head
//               full, empty         - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module swerv_el2_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/swerv_el2_trace_encoder.sv
`default_nettype none
// ============================================================================
// Module      : swerv_el2_trace_encoder
// Description : Captures per-cycle pipeline snapshots (IF/DE/EX/WB/LWB events)
//               into a FIFO and serializes each one as a header word followed
//               by the payload words of its active events, over a
//               valid/ready stream. Stops capturing after the end-of-test
//               marker retires.
// Ports       : clk, rst                        - clock, sync active-high reset
//               if_req, if_pc                   - fetch request / PC
//               de_valid, de_pc, de_insn        - decode stage
//               ex_valid, ex_pc,
//               lsu_nonblock_load_valid         - execute stage
//               wb_valid, wb_pc, load_wb_valid  - writeback stage
//               out_valid/ready/data/last       - trace word stream
//               drop_count                      - snapshots lost to overflow
//               finish                          - end-of-test seen (sticky)
//               idle                            - nothing queued or in flight
// Revision    : 1.0 - initial release
// ============================================================================
module swerv_el2_trace_encoder
  import swerv_el2_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  input  logic        de_valid,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_insn,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        lsu_nonblock_load_valid,
  input  logic [1:0]  wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        load_wb_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] drop_count,
  output logic        finish,
  output logic        idle
);

  logic        if_req_q;
  logic [31:0] if_pc_q;
  logic [15:0] cycle_cnt;
  logic        ovf_pending;
  logic        armed;
  logic [2:0]  state;
  logic [2:0]  cur_state;
  logic [2:0]  nxt_state;
  logic [4:0]  ev_mask;
  logic        push_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic        xfer;
  logic        pop;
  logic        marker_seen;
  logic        armed_now;
  trace_snap_t push_snap;
  trace_snap_t head;

  // A fetch counts as an event only when it is new: a fresh request or a PC change
  always_comb begin
    ev_mask           = '0;
    ev_mask[MASK_WB]  = |wb_valid;
    ev_mask[MASK_LWB] = load_wb_valid;
    ev_mask[MASK_EX]  = ex_valid;
    ev_mask[MASK_DE]  = de_valid;
    ev_mask[MASK_IF]  = if_req && (!if_req_q || (if_pc != if_pc_q));
  end

  assign push_req = (ev_mask != 5'd0) && !finish;

  always_comb begin
    push_snap.ts      = cycle_cnt;
    push_snap.ovf     = ovf_pending;
    push_snap.is_load = ex_valid && lsu_nonblock_load_valid;
    push_snap.mask    = ev_mask;
    push_snap.wb_pc   = wb_pc;
    push_snap.ex_pc   = ex_pc;
    push_snap.de_pc   = de_pc;
    push_snap.de_insn = de_insn;
    push_snap.if_pc   = if_pc;
  end

  swerv_el2_trace_fifo #(
    .WIDTH ($bits(trace_snap_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_snap),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // 'state' only remembers progress inside a record; an idle serializer with a
  // queued entry is already presenting that entry's header, so records run
  // back-to-back without a bubble.
  assign cur_state = (state == ST_IDLE && !fifo_empty) ? ST_HDR : state;
  assign nxt_state = trace_next_state(cur_state, head.mask);
  assign out_valid = (cur_state != ST_IDLE);
  assign out_last  = out_valid && (nxt_state == ST_IDLE);
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && out_last;
  assign idle      = fifo_empty && (state == ST_IDLE);

  always_comb begin
    out_data = '0;
    case (cur_state)
      ST_HDR:   out_data = trace_header(head);
      ST_WB:    out_data = head.wb_pc;
      ST_EX:    out_data = head.ex_pc;
      ST_DEPC:  out_data = head.de_pc;
      ST_DEINS: out_data = head.de_insn;
      ST_IF:    out_data = head.if_pc;
      default:  out_data = '0;
    endcase
  end

  // The marker arms in the same cycle it decodes, so a same-cycle writeback
  // already finishes; the finishing cycle's snapshot is still captured.
  assign marker_seen = de_valid && (de_insn == FINISH_MARKER);
  assign armed_now   = armed || marker_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_req_q    <= 1'b0;
      if_pc_q     <= '0;
      cycle_cnt   <= '0;
      ovf_pending <= 1'b0;
      armed       <= 1'b0;
      finish      <= 1'b0;
      drop_count  <= '0;
      state       <= ST_IDLE;
    end else begin
      if_req_q  <= if_req;
      if_pc_q   <= if_pc;
      cycle_cnt <= cycle_cnt + 16'd1;
      if (marker_seen)
        armed <= 1'b1;
      if (armed_now && (|wb_valid))
        finish <= 1'b1;
      if (push_req) begin
        if (fifo_full) begin
          ovf_pending <= 1'b1;
          if (drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
        end else begin
          ovf_pending <= 1'b0;
        end
      end
      if (xfer)
        state <= nxt_state;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_swerv_el2_trace_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_swerv_el2_trace_encoder
// Description : Self-checking bench for swerv_el2_trace_encoder. A reference
//               model keeps the expected trace as a queue of words built from
//               each cycle's events; DUT outputs are compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_swerv_el2_trace_encoder;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MARK  = 32'h00002013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_pc;
  logic        de_valid;
  logic [31:0] de_pc;
  logic [31:0] de_insn;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        lsu_nonblock_load_valid;
  logic [1:0]  wb_valid;
  logic [31:0] wb_pc;
  logic        load_wb_valid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] drop_count;
  logic        finish;
  logic        idle;

  always #5 clk = ~clk;

  swerv_el2_trace_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .if_req                  (if_req),
    .if_pc                   (if_pc),
    .de_valid                (de_valid),
    .de_pc                   (de_pc),
    .de_insn                 (de_insn),
    .ex_valid                (ex_valid),
    .ex_pc                   (ex_pc),
    .lsu_nonblock_load_valid (lsu_nonblock_load_valid),
    .wb_valid                (wb_valid),
    .wb_pc                   (wb_pc),
    .load_wb_valid           (load_wb_valid),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_data                (out_data),
    .out_last                (out_last),
    .drop_count              (drop_count),
    .finish                  (finish),
    .idle                    (idle)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] w;
    bit          last;
  } word_t;

  // Reference model state
  word_t       q[$];
  int          nrec;
  int          m_drop;
  bit          m_ovf;
  bit          m_arm;
  bit          m_fin;
  bit          m_ifq;
  logic [31:0] m_ifpcq;
  logic [15:0] m_ts;
  bit          model_ok = 1'b0;
  int          pushes   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    if_req                  = 1'b0;
    de_valid                = 1'b0;
    ex_valid                = 1'b0;
    lsu_nonblock_load_valid = 1'b0;
    wb_valid                = 2'b00;
    load_wb_valid           = 1'b0;
  endtask

  task automatic add_word(input logic [31:0] w, input bit last);
    word_t e;
    e.w    = w;
    e.last = last;
    q.push_back(e);
  endtask

  // Compare this cycle's outputs, advance the model by one clock, then clock.
  task automatic cycle();
    logic [4:0]  m;
    logic [31:0] words[6];
    int          n;
    bit          full;
    bit          exp_v;
    exp_v = (q.size() > 0);
    if (model_ok) begin
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v && out_valid) begin
        chk("out_data", out_data, q[0].w);
        chk("out_last", 32'(out_last), 32'(q[0].last));
      end
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      chk("finish", 32'(finish), 32'(m_fin));
      chk("idle", 32'(idle), 32'(nrec == 0));
    end
    if (rst) begin
      q.delete();
      nrec     = 0;
      m_drop   = 0;
      m_ovf    = 1'b0;
      m_arm    = 1'b0;
      m_fin    = 1'b0;
      m_ifq    = 1'b0;
      m_ifpcq  = '0;
      m_ts     = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m[0] = |wb_valid;
      m[1] = load_wb_valid;
      m[2] = ex_valid;
      m[3] = de_valid;
      m[4] = if_req && (!m_ifq || (if_pc != m_ifpcq));
      full = (nrec == DEPTH);
      if (exp_v && out_ready) begin
        if (q[0].last) nrec--;
        void'(q.pop_front());
      end
      if (m != 5'd0 && !m_fin) begin
        if (full) begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1'b1;
        end else begin
          n = 0;
          words[n++] = {m_ts, m_ovf, 9'd0, ex_valid && lsu_nonblock_load_valid, m};
          if (m[0]) words[n++] = wb_pc;
          if (m[2]) words[n++] = ex_pc;
          if (m[3]) begin words[n++] = de_pc; words[n++] = de_insn; end
          if (m[4]) words[n++] = if_pc;
          for (int i = 0; i < n; i++) add_word(words[i], i == n - 1);
          nrec++;
          pushes++;
          m_ovf = 1'b0;
        end
      end
      if (de_valid && de_insn == MARK) m_arm = 1'b1;
      if (m_arm && (|wb_valid)) m_fin = 1'b1;
      m_ifq   = if_req;
      m_ifpcq = if_pc;
      m_ts    = m_ts + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) cycle();
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int p0;
  int thr;

  initial begin
    clr();
    rst       = 1'b1;
    out_ready = 1'b1;
    if_pc     = '0;
    de_pc     = '0;
    de_insn   = '0;
    ex_pc     = '0;
    wb_pc     = '0;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_idle", 32'(idle), 32'd1);

    // Single decode event at timestamp 5
    for (int i = 0; i < 10 && m_ts != 16'd5; i++) cycle();
    de_valid = 1'b1;
    de_pc    = 32'h80000010;
    de_insn  = 32'h00A00093;
    cycle();
    clr();
    chk("de_header", out_data, 32'h00050008);
    chk("de_latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Held fetch PC yields one record; a PC change yields another
    p0     = pushes;
    if_req = 1'b1;
    if_pc  = 32'h100;
    repeat (3) cycle();
    if_pc = 32'h104;
    cycle();
    clr();
    drain();
    chk("if_records", 32'(pushes - p0), 32'd2);

    // All events in the same cycle
    wb_valid                = 2'b10;
    wb_pc                   = 32'hAAAA0000;
    load_wb_valid           = 1'b1;
    ex_valid                = 1'b1;
    ex_pc                   = 32'hBBBB0004;
    lsu_nonblock_load_valid = 1'b1;
    de_valid                = 1'b1;
    de_pc                   = 32'hCCCC0008;
    de_insn                 = 32'h00112233;
    if_req                  = 1'b1;
    if_pc                   = 32'hDDDD000C;
    cycle();
    clr();
    chk("all_hdr_low", 32'(out_data[5:0]), 32'h3F);
    drain();

    // Overflow: ten events against a stalled sink
    do_reset();
    out_ready = 1'b0;
    de_insn   = 32'h00000013;
    for (int i = 0; i < 10; i++) begin
      de_valid = 1'b1;
      de_pc    = 32'h2000 + 32'(i * 4);
      cycle();
    end
    clr();
    chk("drop_count_10", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    drain();
    de_valid = 1'b1;
    cycle();
    clr();
    chk("ovf_hdr_set", 32'(out_data[15]), 32'd1);
    drain();
    de_valid = 1'b1;
    cycle();
    clr();
    chk("ovf_hdr_clear", 32'(out_data[15]), 32'd0);
    drain();

    // Randomized traffic, first with a mostly-ready sink, then a slow one
    for (int i = 0; i < 600; i++) begin
      thr                     = (i < 300) ? 7 : 2;
      if_req                  = ($urandom_range(0, 3) != 0);
      if_pc                   = 32'h100 + 32'($urandom_range(0, 3) * 4);
      de_valid                = ($urandom_range(0, 3) == 0);
      de_pc                   = $urandom;
      de_insn                 = $urandom;
      if (de_insn == MARK) de_insn = de_insn ^ 32'h1;
      ex_valid                = ($urandom_range(0, 3) == 0);
      ex_pc                   = $urandom;
      lsu_nonblock_load_valid = ($urandom_range(0, 1) == 0);
      wb_valid                = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wb_pc                   = $urandom;
      load_wb_valid           = ($urandom_range(0, 4) == 0);
      out_ready               = ($urandom_range(0, 9) < thr);
      cycle();
    end
    clr();
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a record while the sink toggles
    wb_valid = 2'b01;
    wb_pc    = 32'h3000;
    de_valid = 1'b1;
    de_pc    = 32'h3004;
    de_insn  = 32'h00000033;
    cycle();
    clr();
    out_ready = 1'b0;
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    rst       = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_drop", 32'(drop_count), 32'd0);
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("midrst_quiet", 32'(out_valid), 32'd0);

    // End-of-test marker then retirement two cycles later
    de_valid = 1'b1;
    de_pc    = 32'h4000;
    de_insn  = MARK;
    cycle();
    clr();
    cycle();
    wb_valid = 2'b01;
    wb_pc    = 32'h4000;
    cycle();
    clr();
    chk("finish_set", 32'(finish), 32'd1);
    p0 = pushes;
    for (int i = 0; i < 5; i++) begin
      de_valid = 1'b1;
      de_pc    = 32'h5000 + 32'(i * 4);
      de_insn  = 32'h00000013;
      if_req   = 1'b1;
      if_pc    = 32'h6000 + 32'(i * 4);
      cycle();
    end
    clr();
    drain();
    cycle();
    chk("finish_no_records", 32'(pushes - p0), 32'd0);
    chk("finish_idle", 32'(idle), 32'd1);
    chk("finish_drop", 32'(drop_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
